// File: rtl/lcd_ghost.sv
// LCD persistence ("ghosting") emulation: each scanout shade is blended with the
// value previously shown at the same screen position, held in a history RAM.
module lcd_ghost #(
    parameter int ACT_W = 160,
    parameter int ACT_H = 160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [1:0] pixel_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    input  logic [1:0] ghost_mode,
    output logic [3:0] pixel_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       hblank_out,
    output logic       vblank_out
);

    localparam int DEPTH = ACT_W * ACT_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW    = $clog2(ACT_W + 1);
    localparam int YW    = $clog2(ACT_H + 1);

    // mode = 0 means "pass shade through" (blank, out of range, priming or mode off)
    typedef struct packed {
        logic [3:0]    shade;
        logic [AW-1:0] addr;
        logic          wr;
        logic [1:0]    mode;
        logic [3:0]    tim;
    } stage_t;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_act_q, line_act_d;
    logic          vb_prev_q, vb_prev_d;
    logic [1:0]    frame_mode_q, frame_mode_d;
    logic          prime_q, prime_d;
    logic          start_ok_q, start_ok_d;
    logic          v0_q, v0_d;
    logic          v1_q, v1_d;
    stage_t        st0_q, st0_d;
    stage_t        st1_q, st1_d;
    logic [3:0]    pixel_out_q, pixel_out_d;
    logic [3:0]    tim_out_q, tim_out_d;
    logic [3:0]    n;
    logic          in_range;
    logic [3:0]    hist_rd;
    logic [3:0]    hist_mem [DEPTH];

    // Position tracking, frame-mode latch and priming control.
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        line_act_d   = line_act_q;
        vb_prev_d    = vb_prev_q;
        frame_mode_d = frame_mode_q;
        start_ok_d   = start_ok_q;
        prime_d      = prime_q || (frame_mode_q == 2'd0);
        if (ce_pix) begin
            vb_prev_d = vblank_in;
            if (vb_prev_q && !vblank_in) begin
                frame_mode_d = ghost_mode;
                start_ok_d   = prime_q && (ghost_mode != 2'd0);
            end
            if (!vb_prev_q && vblank_in) begin
                if (start_ok_q && (frame_mode_q != 2'd0)) prime_d = 1'b0;
                start_ok_d = 1'b0;
            end
            if (hblank_in) begin
                x_d        = '0;
                line_act_d = 1'b0;
                if (line_act_q && (y_q != YW'(ACT_H))) y_d = y_q + YW'(1);
            end else if (!vblank_in) begin
                line_act_d = 1'b1;
                if (x_q != XW'(ACT_W)) x_d = x_q + XW'(1);
            end
            if (vblank_in) begin
                y_d        = '0;
                line_act_d = 1'b0;
            end
        end
    end

    // Blank pixels never write: an hblank strobe sits at x=0 of the next line and
    // would otherwise overwrite history before that pixel is displayed.
    assign in_range = !hblank_in && !vblank_in &&
                      (x_q < XW'(ACT_W)) && (y_q < YW'(ACT_H));

    always_comb begin
        v0_d  = ce_pix;
        st0_d = st0_q;
        if (ce_pix) begin
            st0_d.shade = {pixel_in, 2'b00} + {2'b00, pixel_in};
            st0_d.addr  = AW'(y_q) * AW'(ACT_W) + AW'(x_q);
            st0_d.wr    = in_range;
            st0_d.mode  = (in_range && !prime_q) ? frame_mode_d : 2'd0;
            st0_d.tim   = {hsync_in, vsync_in, hblank_in, vblank_in};
        end
        v1_d  = v0_q;
        st1_d = st0_q;
    end

    always_comb begin
        case (st1_q.mode)
            2'd0:    n = st1_q.shade;
            2'd1:    n = 4'((6'(st1_q.shade) + 6'(hist_rd) + 6'd1) >> 1);
            default: n = 4'((6'(st1_q.shade) + 6'(hist_rd) * 6'd3 + 6'd2) >> 2);
        endcase
        pixel_out_d = v1_q ? n : pixel_out_q;
        tim_out_d   = v1_q ? st1_q.tim : tim_out_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            line_act_q   <= 1'b0;
            vb_prev_q    <= 1'b0;
            frame_mode_q <= 2'd0;
            prime_q      <= 1'b1;
            start_ok_q   <= 1'b0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            pixel_out_q  <= 4'd0;
            tim_out_q    <= 4'd0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            line_act_q   <= line_act_d;
            vb_prev_q    <= vb_prev_d;
            frame_mode_q <= frame_mode_d;
            prime_q      <= prime_d;
            start_ok_q   <= start_ok_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            pixel_out_q  <= pixel_out_d;
            tim_out_q    <= tim_out_d;
        end
    end

    // Datapath payload is qualified by v0_q/v1_q and needs no reset.
    always_ff @(posedge clk) begin
        st0_q <= st0_d;
        st1_q <= st1_d;
    end

    // NOTE: the history RAM is deliberately not reset; prime masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && v1_q && st1_q.wr) hist_mem[st1_q.addr] <= n;
        hist_rd <= hist_mem[st0_q.addr];
    end

    assign pixel_out = pixel_out_q;
    assign {hsync_out, vsync_out, hblank_out, vblank_out} = tim_out_q;

endmodule

// File: tb/tb_lcd_ghost.sv
// Directed bench for lcd_ghost on a 4x3 active area: every pixel strobe is checked
// for hold at +1 clk and for the expected shade/timing at +2 clk.
module tb_lcd_ghost;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [1:0] pixel_in;
    logic       hsync_in, vsync_in, hblank_in, vblank_in;
    logic [1:0] ghost_mode;
    logic [3:0] pixel_out;
    logic       hsync_out, vsync_out, hblank_out, vblank_out;
    logic [7:0] obs;
    logic [7:0] last_exp;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    lcd_ghost #(.ACT_W(W), .ACT_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .pixel_in   (pixel_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .ghost_mode (ghost_mode),
        .pixel_out  (pixel_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblank_out (hblank_out),
        .vblank_out (vblank_out)
    );

    assign obs = {pixel_out, hsync_out, vsync_out, hblank_out, vblank_out};

    task automatic check(input string tag, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One strobe; outputs must hold at +1 clk and show {exp, timing} at +2 clk.
    task automatic ce_step(input logic [1:0] p, input logic hs, input logic vs,
                           input logic hb, input logic vb, input logic [3:0] exp,
                           input string tag);
        logic [7:0] e;
        e = {exp, hs, vs, hb, vb};
        @(negedge clk);
        pixel_in = p;
        {hsync_in, vsync_in, hblank_in, vblank_in} = {hs, vs, hb, vb};
        ce_pix = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ce_pix = 1'b0;
        @(posedge clk);
        #1 check({tag, "_hold"}, last_exp);
        @(posedge clk);
        #1 check(tag, e);
        last_exp = e;
    endtask

    // Two vblank strobes, then H lines of W active pixels each followed by one hblank.
    task automatic run_frame(input logic [1:0] p, input logic [3:0] exp, input string tag,
                             input bit chg = 1'b0, input logic [1:0] chg_mode = 2'd0,
                             input bit extra = 1'b0);
        ce_step(2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, {tag, "_vb0"});
        ce_step(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, {tag, "_vb1"});
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++)
                ce_step(p, 1'b0, 1'b0, 1'b0, 1'b0, exp, $sformatf("%s_x%0dy%0d", tag, x, y));
            if (extra && y == 0) ce_step(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, {tag, "_oor"});
            ce_step(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, $sformatf("%s_hb%0d", tag, y));
            if (chg && y == 0) ghost_mode = chg_mode;
        end
    endtask

    initial begin
        reset = 1'b1;
        ce_pix = 1'b0;
        pixel_in = 2'd0;
        {hsync_in, vsync_in, hblank_in, vblank_in} = 4'b0000;
        ghost_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", 8'h00);
        last_exp = 8'h00;
        @(negedge clk);
        reset = 1'b0;

        // Mode 0: plain pass-through of shade 10.
        run_frame(2'd1 + 2'd1, 4'd10, "m0");

        // Mode 1: primed 15-frame, then 0-frames decay 8, 4, 2, 1.
        ghost_mode = 2'd1;
        run_frame(2'd3, 4'd15, "m1a");
        run_frame(2'd0, 4'd8,  "m1b");
        run_frame(2'd0, 4'd4,  "m1c");
        run_frame(2'd0, 4'd2,  "m1d");
        run_frame(2'd0, 4'd1,  "m1e");

        // Mode 2: re-prime through mode 0, then (0+45+2)>>2 = 11, (0+33+2)>>2 = 8.
        ghost_mode = 2'd0;
        run_frame(2'd3, 4'd15, "m2p0");
        ghost_mode = 2'd2;
        run_frame(2'd3, 4'd15, "m2p1");
        run_frame(2'd0, 4'd11, "m2a");
        run_frame(2'd0, 4'd8,  "m2b");

        // Reset mid-frame at x=2, y=1 with mode 1 blending against history 8.
        ghost_mode = 2'd1;
        ce_step(2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, "r_vb0");
        ce_step(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, "r_vb1");
        for (int x = 0; x < W; x++)
            ce_step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, $sformatf("r_pre_x%0dy0", x));
        ce_step(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, "r_hb0");
        ce_step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, "r_pre_x0y1");
        ce_step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, "r_pre_x1y1");
        @(negedge clk);
        reset = 1'b1;
        ce_pix = 1'b1;
        pixel_in = 2'd3;
        {hsync_in, vsync_in, hblank_in, vblank_in} = 4'b1111;
        @(posedge clk);
        #1 check("r_out_zero", 8'h00);
        last_exp = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        ce_pix = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("r_ce_ignored", 8'h00);
        ce_step(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, "r_post_x2y1");
        ce_step(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, "r_post_x3y1");
        ce_step(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, "r_hb1");
        for (int x = 0; x < W; x++)
            ce_step(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, $sformatf("r_post_x%0dy2", x));
        ce_step(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, "r_hb2");
        run_frame(2'd0, 4'd0, "r_full");
        run_frame(2'd3, 4'd8, "r_blend");

        // ghost_mode 0->1 mid-frame: blending only after the first full mode-1 frame.
        ghost_mode = 2'd0;
        run_frame(2'd3, 4'd15, "g_a");
        run_frame(2'd0, 4'd0,  "g_b", 1'b1, 2'd1);
        run_frame(2'd3, 4'd15, "g_c");
        run_frame(2'd0, 4'd8,  "g_d");

        // Out-of-range pixel (x=W) passes through and must not alias into line 1.
        run_frame(2'd0, 4'd4, "o_a", 1'b0, 2'd0, 1'b1);
        run_frame(2'd0, 4'd2, "o_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
